// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I execute block: FUNCT3 encodings,
// FSM state type and a small decode helper.
package alu_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == F3_SLL) || (funct3 == F3_SRL);
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Operand/result handshake bundle between the issue stage and alu_exec.
interface alu_exec_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [2:0]  funct3;
  logic        alt;
  logic        is_reg;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  modport master (
    output in_valid, data0, data1, funct3, alt, is_reg, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, data0, data1, funct3, alt, is_reg, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/alu_serial_shift.sv
// One-bit-per-cycle shifter: loads an operand and count, then steps
// left, logical-right or arithmetic-right until the count reaches zero.
module alu_serial_shift (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  amount_i,
  input  logic        dir_left_i,
  input  logic        arith_i,
  output logic [31:0] data_o,
  output logic        done_o
);

  logic [31:0] data_q, data_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        arith_q, arith_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    data_d  = data_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    arith_d = arith_q;
    if (load_i) begin
      data_d  = data_i;
      cnt_d   = amount_i;
      left_d  = dir_left_i;
      arith_d = arith_i;
    end else if (cnt_q != 5'd0) begin
      cnt_d  = cnt_q - 5'd1;
      data_d = left_q ? {data_q[30:0], 1'b0}
                      : {arith_q & data_q[31], data_q[31:1]};
    end
  end

  assign data_o = data_q;
  // Done means the count is zero after the coming edge, so the caller can
  // leave its shift state on the same edge as the final step.
  assign done_o = (cnt_d == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      data_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      arith_q <= arith_d;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// RV32I integer execute unit: single-cycle logic/arith ops and an
// iterative shifter, behind a valid/ready operand and result handshake.
module alu_exec
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  bus
);

  state_e      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [2:0]  f3_q;
  logic        sub_q;
  logic        take;
  logic [4:0]  amount;
  logic [31:0] sh_data;
  logic        sh_done;
  logic [31:0] alu_res;

  assign take   = bus.in_valid && bus.in_ready;
  assign amount = bus.data1[4:0];

  alu_serial_shift u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (take),
    .data_i     (bus.data0),
    .amount_i   (amount),
    .dir_left_i (bus.funct3 == F3_SLL),
    .arith_i    ((bus.funct3 == F3_SRL) && bus.alt),
    .data_o     (sh_data),
    .done_o     (sh_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (take) state_d = (is_shift(bus.funct3) && amount != 5'd0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (sh_done) state_d = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= F3_ADD;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        a_q   <= bus.data0;
        b_q   <= bus.data1;
        f3_q  <= bus.funct3;
        // Immediate forms reuse bit 30 as data, so only R-type selects SUB.
        sub_q <= bus.alt && bus.is_reg;
      end
    end
  end

  always_comb begin
    alu_res = '0;
    case (f3_q)
      F3_ADD:         alu_res = sub_q ? (a_q - b_q) : (a_q + b_q);
      F3_SLT:         alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
      F3_SLTU:        alu_res = {31'd0, a_q < b_q};
      F3_XOR:         alu_res = a_q ^ b_q;
      F3_OR:          alu_res = a_q | b_q;
      F3_AND:         alu_res = a_q & b_q;
      F3_SLL, F3_SRL: alu_res = sh_data;
      default:        alu_res = '0;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.result    = bus.out_valid ? alu_res : 32'd0;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed corner vectors plus random
// operations compared against a behavioural RV32I model.
module tb_alu_exec;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_exec_if bus ();

  alu_exec u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        alt;
    logic        is_reg;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t dir_vecs [10];

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic alt,
                                          input logic is_reg);
    int unsigned n;
    logic [31:0] r;
    n = b[4:0];
    case (f3)
      3'd0: r = (alt && is_reg) ? a - b : a + b;
      3'd1: r = a << n;
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: r = alt ? 32'($signed(a) >>> n) : (a >> n);
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [31:0] b, input logic [2:0] f3);
    return (f3 == 3'd1 || f3 == 3'd5) ? 1 + int'(b[4:0]) : 1;
  endfunction

  // Transfers one bundle, scrambles the inputs, and waits for OUT_VALID with
  // OUT_READY held low; returns at the negedge where the result is visible.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input logic alt, input logic is_reg,
                       output logic [31:0] res, output int lat, output bit timeout,
                       output int bad_zero);
    int k;
    timeout  = 1'b0;
    bad_zero = 0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.data0 = a; bus.data1 = b; bus.funct3 = f3; bus.alt = alt; bus.is_reg = is_reg;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) timeout = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.data0 = $urandom; bus.data1 = $urandom; bus.funct3 = 3'($urandom);
    bus.alt = 1'($urandom); bus.is_reg = 1'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.out_valid && bus.result !== 32'd0) bad_zero++;
    end while (!bus.out_valid && lat < 200);
    if (!bus.out_valid) timeout = 1'b1;
    res = bus.result;
  endtask

  task automatic release_op();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.data0 = '0; bus.data1 = '0;
    bus.funct3 = '0; bus.alt = 1'b0; bus.is_reg = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++;
    if (bus.result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] res;
    int lat, bad;
    bit to;
    dir_vecs = '{
      '{32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 1'b0, 1'b1, 32'h0000_0000, 1},
      '{32'h0000_0005, 32'h0000_0007, 3'd0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1},
      '{32'h0000_0005, 32'h0000_0007, 3'd0, 1'b1, 1'b0, 32'h0000_000C, 1},
      '{32'h8000_0000, 32'h0000_0024, 3'd5, 1'b1, 1'b0, 32'hF800_0000, 5},
      '{32'h8000_0000, 32'h0000_0024, 3'd5, 1'b0, 1'b0, 32'h0800_0000, 5},
      '{32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 1'b0, 1'b1, 32'h0000_0001, 1},
      '{32'hFFFF_FFFF, 32'h0000_0001, 3'd3, 1'b0, 1'b1, 32'h0000_0000, 1},
      '{32'h0000_0001, 32'h0000_0020, 3'd1, 1'b0, 1'b0, 32'h0000_0001, 1},
      '{32'h0000_0003, 32'h0000_001F, 3'd1, 1'b0, 1'b1, 32'h8000_0000, 32},
      '{32'h8000_0000, 32'hFFFF_FFE0, 3'd5, 1'b1, 1'b1, 32'h8000_0000, 1}
    };
    for (int i = 0; i < 10; i++) begin
      do_op(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].f3, dir_vecs[i].alt, dir_vecs[i].is_reg,
            res, lat, to, bad);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL directed_%0d_timeout: no OUT_VALID", i); end
      n_checks++;
      if (res !== dir_vecs[i].exp) begin
        n_fail++; $display("FAIL directed_%0d_result: got %h want %h", i, res, dir_vecs[i].exp);
      end
      n_checks++;
      if (lat != dir_vecs[i].lat) begin
        n_fail++; $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, dir_vecs[i].lat);
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL directed_%0d_result_zero: %0d nonzero idle cycles want 0", i, bad); end
      release_op();
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'd0) begin
        n_fail++;
        $display("FAIL directed_%0d_return_idle: in_ready %b out_valid %b result %h want 1 0 0",
                 i, bus.in_ready, bus.out_valid, bus.result);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp;
    logic [2:0] f3;
    logic alt, is_reg;
    int lat, bad, exp_lat;
    bit to;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; f3 = 3'($urandom_range(0, 7));
      alt = 1'($urandom); is_reg = 1'($urandom);
      if (i % 4 == 0) b = $urandom_range(0, 40);
      exp     = ref_alu(a, b, f3, alt, is_reg);
      exp_lat = ref_latency(b, f3);
      do_op(a, b, f3, alt, is_reg, res, lat, to, bad);
      n_checks++;
      if (res !== exp || to) begin
        n_fail++;
        $display("FAIL random_%0d_result f3=%0d alt=%b reg=%b a=%h b=%h: got %h want %h",
                 i, f3, alt, is_reg, a, b, res, exp);
      end
      n_checks++;
      if (lat != exp_lat || bad != 0) begin
        n_fail++;
        $display("FAIL random_%0d_latency f3=%0d: got %0d (nonzero idle %0d) want %0d", i, f3, lat, bad, exp_lat);
      end
      release_op();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, res, exp;
    int lat, bad;
    bit to;
    a = $urandom; b = $urandom;
    exp = a ^ b;
    do_op(a, b, 3'd4, 1'b0, 1'b1, res, lat, to, bad);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.result !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: result %h out_valid %b in_ready %b want %h 1 0",
                 i, bus.result, bus.out_valid, bus.in_ready, exp);
      end
    end
    release_op();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: in_ready %b busy %b want 1 0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int shift_n [6] = '{0, 3, 0, 7, 1, 0};
    int t, prev_t, k;
    bus.out_ready = 1'b1;
    prev_t = 0;
    for (int i = 0; i < 6; i++) begin
      k = 0;
      @(negedge clk);
      while (!bus.in_ready && k < 100) begin
        @(negedge clk);
        k++;
      end
      t = cyc;
      bus.data0 = $urandom;
      bus.data1 = 32'(shift_n[i]);
      bus.funct3 = (shift_n[i] == 0) ? 3'd0 : 3'd5;
      bus.alt = 1'b0; bus.is_reg = 1'b1;
      bus.in_valid = 1'b1;
      if (i > 0) begin
        n_checks++;
        if (t - prev_t != 2 + shift_n[i-1] || k >= 100) begin
          n_fail++;
          $display("FAIL back_to_back_%0d_spacing: got %0d cycles want %0d", i, t - prev_t, 2 + shift_n[i-1]);
        end
      end
      prev_t = t;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 0;
    while (bus.busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] res;
    int lat, bad, stale;
    bit to;
    @(negedge clk);
    bus.data0 = 32'hFFFF_FFFF; bus.data1 = 32'd31; bus.funct3 = 3'd5; bus.alt = 1'b0; bus.is_reg = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_shift_busy: got %b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_shift_reset: out_valid %b result %h in_ready %b busy %b want 0 0 1 0",
               bus.out_valid, bus.result, bus.in_ready, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) stale++;
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if (stale != 0) begin n_fail++; $display("FAIL mid_shift_stale: got %0d valid cycles want 0", stale); end
    do_op(32'd2, 32'd3, 3'd0, 1'b0, 1'b1, res, lat, to, bad);
    n_checks++;
    if (res !== 32'd5 || lat != 1 || to) begin
      n_fail++; $display("FAIL after_reset_op: got %h lat %0d want 00000005 lat 1", res, lat);
    end
    release_op();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 IN_VALID  input  1  operand bundle valid.
REQ-005 IN_READY  output  1  block can accept a bundle.
REQ-006 DATA0  input  32  first operand (RS1, PC or zero, as selected upstream).
REQ-007 DATA1  input  32  second operand (RS2, immediate or shift amount).
REQ-008 FUNCT3  input  3  RV32I operation select.
REQ-009 ALT  input  1  instruction bit 30; selects SUB or SRA.
REQ-010 IS_REG  input  1  register-register form; ALT selects SUB only when 1.
REQ-011 OUT_VALID  output  1  RESULT valid.
REQ-012 OUT_READY  input  1  consumer accepts RESULT.
REQ-013 RESULT  output  32  operation result.
REQ-014 BUSY  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-016 IN_READY SHALL be 1 only in IDLE; a transfer occurs on the edge where IN_VALID and IN_READY are both 1.
REQ-017 On transfer, all inputs SHALL be captured; later input changes SHALL NOT affect the operation.
REQ-018 FUNCT3 decode:
- 000: ADD, or SUB when ALT and IS_REG are both 1.
- 010: SLT, signed compare.
- 011: SLTU, unsigned compare.
- 100: XOR.
- 110: OR.
- 111: AND.
- 001: SLL.
- 101: SRL, or SRA when ALT is 1.
REQ-019 Arithmetic SHALL wrap modulo 2^32; SLT/SLTU results SHALL be 32'd0 or 32'd1.
REQ-020 Non-shift ops: the FSM SHALL go IDLE->DONE with RESULT computed; OUT_VALID SHALL assert in the cycle after transfer.
REQ-021 Shifts: shift amount n = DATA1[4:0]; DATA1[31:5] SHALL be ignored.
REQ-022 Shift with n=0: the FSM SHALL go IDLE->DONE with RESULT = DATA0; latency SHALL be 1 cycle.
REQ-023 Shift with n>0: the FSM SHALL go to SHIFT and shift one bit per cycle for exactly n cycles, then go to DONE; OUT_VALID SHALL assert 1+n cycles after transfer.
REQ-024 SRA SHALL replicate bit 31 on each step; SRL and SLL SHALL insert 0.
REQ-025 In DONE, RESULT and OUT_VALID SHALL hold until OUT_VALID and OUT_READY are both 1; the FSM SHALL then return to IDLE.
REQ-026 No new transfer SHALL occur in the same cycle as a result handshake; minimum spacing is 2+n cycles.
REQ-027 RESULT SHALL be 32'd0 whenever OUT_VALID is 0.

Reset
REQ-028 Reset assertion at any time SHALL force:
- state IDLE, IN_READY 1;
- OUT_VALID 0, BUSY 0, RESULT 32'd0;
- shift counter 0.
REQ-029 An operation in flight at reset SHALL be discarded with no output handshake.
REQ-030 After deassertion, the first transfer SHALL be accepted on the first rising edge with IN_VALID high.

Structure
REQ-031 A shared package alu_pkg SHALL hold the FUNCT3 encoding constants and the FSM state enum.
REQ-032 The iterative shifter SHALL be a sub-module alu_serial_shift (load, one-bit step, direction, arithmetic flag, done-on-count-zero).
REQ-033 All single-cycle ops SHALL be computed combinationally from captured operands inside alu_exec.

Verification
REQ-034 ADD 0xFFFFFFFF + 0x00000001 -> RESULT 0x00000000, OUT_VALID 1 cycle after transfer.
REQ-035 SUB with IS_REG=1, ALT=1, 5-7 -> 0xFFFFFFFE; same inputs with IS_REG=0 -> 0x0000000C.
REQ-036 SRA of 0x80000000 by DATA1=0x00000024 (n=4) -> 0xF8000000, OUT_VALID 5 cycles after transfer; SRL of the same -> 0x08000000.
REQ-037 SLT 0xFFFFFFFF vs 0x00000001 -> 1; SLTU with the same operands -> 0.
REQ-038 Backpressure: OUT_READY low 3 cycles -> RESULT stable, IN_READY 0; release -> IDLE next cycle, IN_READY 1.
REQ-039 RST_N pulsed low mid-SHIFT (n=31) -> OUT_VALID 0, RESULT 0, IN_READY 1 immediately; no stale result afterwards.
